// File: rtl/alu_op_sequencer.sv
// Initiator for the 32-bit combinational ALU: accepts tagged commands, holds operands on the
// ALU for SETTLE_CYC cycles, captures the result and returns it on a valid/ready response port.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_a,
  input  logic [31:0]       req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [2:0]        alu_operation,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_c,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_carry_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_c,
  output logic              rsp_zero,
  output logic              rsp_ovf,
  output logic              rsp_cout,
  output logic              rsp_err,
  output logic [TAG_W-1:0]  rsp_tag,
  input  logic              clr_sts,
  output logic              sts_ovf_sticky,
  output logic              sts_err_sticky,
  output logic [CNT_W-1:0]  op_count
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned SC_W  = $clog2(SETTLE_CYC + 1);
  localparam logic [OP_W-1:0] OP_ILLEGAL = OP_W'(0);
  localparam logic [SC_W-1:0] SC_LAST    = SC_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [SC_W-1:0]   settle_cnt;
  logic              accept_c;
  logic              illegal_c;
  logic              capture_c;
  logic              rsp_done_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the one-cycle event strobes that steer the datapath registers.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    accept_c   = 1'b0;
    illegal_c  = 1'b0;
    capture_c  = 1'b0;
    rsp_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept_c = 1'b1;
          if (req_op == OP_ILLEGAL) begin
            illegal_c = 1'b1;
            state_d   = RESP;
          end else begin
            state_d   = DRIVE;
          end
        end
      end
      DRIVE: begin
        if (settle_cnt == SC_LAST) begin
          capture_c = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done_c = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU drive: operands persist after the op, the opcode is only non-zero while in DRIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_operation <= OP_W'(0);
      alu_a         <= 32'd0;
      alu_b         <= 32'd0;
      settle_cnt    <= SC_W'(0);
    end else begin
      if (accept_c) begin
        alu_a      <= req_a;
        alu_b      <= req_b;
        settle_cnt <= SC_W'(0);
        if (!illegal_c) alu_operation <= req_op;
      end else if (state_q == DRIVE) begin
        settle_cnt <= settle_cnt + SC_W'(1);
      end
      if (capture_c) alu_operation <= OP_W'(0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_c     <= 32'd0;
      rsp_zero  <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_cout  <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_tag   <= TAG_W'(0);
    end else begin
      if (accept_c) begin
        rsp_tag <= req_tag;
        rsp_err <= illegal_c;
        if (illegal_c) begin
          rsp_c    <= 32'd0;
          rsp_zero <= 1'b0;
          rsp_ovf  <= 1'b0;
          rsp_cout <= 1'b0;
        end
      end
      if (capture_c) begin
        rsp_c    <= alu_c;
        rsp_zero <= alu_zero;
        rsp_ovf  <= alu_overflow;
        rsp_cout <= alu_carry_out;
      end
      if (capture_c || illegal_c) rsp_valid <= 1'b1;
      else if (rsp_done_c)        rsp_valid <= 1'b0;
    end
  end

  // Sticky status: a set on the same edge as clr_sts wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sts_ovf_sticky <= 1'b0;
      sts_err_sticky <= 1'b0;
      op_count       <= CNT_W'(0);
    end else begin
      sts_ovf_sticky <= (sts_ovf_sticky & ~clr_sts) | (capture_c & alu_overflow);
      sts_err_sticky <= (sts_err_sticky & ~clr_sts) | illegal_c;
      if (rsp_done_c) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: one instance with a 1-cycle settle and 16-bit counter,
// one with a 3-cycle settle and 2-bit counter; ALU is a scripted stub or a reference model.
module tb_alu_op_sequencer;

  typedef struct packed {
    logic [31:0] c;
    logic        zero;
    logic        ovf;
    logic        cout;
    logic        err;
    logic [3:0]  tag;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_tag;
  logic        clr_sts;
  logic        use_real;
  logic [31:0] stub_c;
  logic        stub_zero, stub_ovf, stub_cout;

  logic        req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a;
  logic [2:0]  alu_operation_a;
  logic [31:0] alu_a_a, alu_b_a, alu_c_a, rsp_c_a;
  logic        alu_zero_a, alu_overflow_a, alu_carry_out_a;
  logic        rsp_zero_a, rsp_ovf_a, rsp_cout_a, rsp_err_a;
  logic [3:0]  rsp_tag_a;
  logic        sts_ovf_a, sts_err_a;
  logic [15:0] op_count_a;

  logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b;
  logic [2:0]  alu_operation_b;
  logic [31:0] alu_a_b, alu_b_b, rsp_c_b;
  logic        rsp_zero_b, rsp_ovf_b, rsp_cout_b, rsp_err_b;
  logic [3:0]  rsp_tag_b;
  logic        sts_ovf_b, sts_err_b;
  logic [1:0]  op_count_b;

  rsp_t exp_q_a[$];
  rsp_t exp_q_b[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_op_sequencer #(.SETTLE_CYC(1), .TAG_W(4), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_operation(alu_operation_a), .alu_a(alu_a_a), .alu_b(alu_b_a),
    .alu_c(alu_c_a), .alu_zero(alu_zero_a), .alu_overflow(alu_overflow_a),
    .alu_carry_out(alu_carry_out_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_c(rsp_c_a),
    .rsp_zero(rsp_zero_a), .rsp_ovf(rsp_ovf_a), .rsp_cout(rsp_cout_a),
    .rsp_err(rsp_err_a), .rsp_tag(rsp_tag_a),
    .clr_sts(clr_sts), .sts_ovf_sticky(sts_ovf_a), .sts_err_sticky(sts_err_a),
    .op_count(op_count_a)
  );

  alu_op_sequencer #(.SETTLE_CYC(3), .TAG_W(4), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_operation(alu_operation_b), .alu_a(alu_a_b), .alu_b(alu_b_b),
    .alu_c(stub_c), .alu_zero(stub_zero), .alu_overflow(stub_ovf),
    .alu_carry_out(stub_cout),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_c(rsp_c_b),
    .rsp_zero(rsp_zero_b), .rsp_ovf(rsp_ovf_b), .rsp_cout(rsp_cout_b),
    .rsp_err(rsp_err_b), .rsp_tag(rsp_tag_b),
    .clr_sts(clr_sts), .sts_ovf_sticky(sts_ovf_b), .sts_err_sticky(sts_err_b),
    .op_count(op_count_b)
  );

  // Reference 32-bit ALU: {zero, overflow, carry_out, c}
  function automatic logic [34:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] c;
    logic        ov, co;
    s = '0; c = '0; ov = 1'b0; co = 1'b0;
    case (op)
      3'b001: begin
        s = {1'b0, a} + {1'b0, b}; c = s[31:0]; co = s[32];
        ov = (a[31] == b[31]) && (c[31] != a[31]);
      end
      3'b010, 3'b111: begin
        s = {1'b0, a} - {1'b0, b}; c = s[31:0]; co = ~s[32];
        ov = (a[31] != b[31]) && (c[31] != a[31]);
      end
      3'b011: c = a & b;
      3'b100: c = a | b;
      3'b101: c = ~(a | b);
      3'b110: c = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: c = '0;
    endcase
    return {(c == 32'd0), ov, co, c};
  endfunction

  always_comb begin
    if (use_real)
      {alu_zero_a, alu_overflow_a, alu_carry_out_a, alu_c_a} =
        ref_alu(alu_operation_a, alu_a_a, alu_b_a);
    else
      {alu_zero_a, alu_overflow_a, alu_carry_out_a, alu_c_a} =
        {stub_zero, stub_ovf, stub_cout, stub_c};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Response monitors: a handshake seen at the negedge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid_a && rsp_ready_a) begin
      if (exp_q_a.size() == 0) check_eq("a_rsp_unexpected", 64'(1), 64'(0));
      else check_eq("a_rsp", 64'(rsp_t'{rsp_c_a, rsp_zero_a, rsp_ovf_a, rsp_cout_a,
                                        rsp_err_a, rsp_tag_a}), 64'(exp_q_a.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid_b && rsp_ready_b) begin
      if (exp_q_b.size() == 0) check_eq("b_rsp_unexpected", 64'(1), 64'(0));
      else check_eq("b_rsp", 64'(rsp_t'{rsp_c_b, rsp_zero_b, rsp_ovf_b, rsp_cout_b,
                                        rsp_err_b, rsp_tag_b}), 64'(exp_q_b.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a request, push its expected response, return 1ns after the accept edge.
  task automatic send(input bit to_b, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] tag, input rsp_t exp);
    logic rdy;
    req_op = op; req_a = a; req_b = b; req_tag = tag;
    if (to_b) begin req_valid_b = 1'b1; exp_q_b.push_back(exp); end
    else      begin req_valid_a = 1'b1; exp_q_a.push_back(exp); end
    rdy = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = to_b ? req_ready_b : req_ready_a;
      if (rdy) break;
    end
    check_eq("accept", 64'(rdy), 64'(1));
    step();
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
  endtask

  task automatic wait_done(input bit to_b);
    logic rdy;
    rdy = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = to_b ? req_ready_b : req_ready_a;
      if (rdy) break;
    end
    check_eq("done_timeout", 64'(rdy), 64'(1));
  endtask

  initial begin
    rst_n = 1'b0; req_valid_a = 1'b0; req_valid_b = 1'b0; rsp_ready_a = 1'b0;
    rsp_ready_b = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    clr_sts = 1'b0; use_real = 1'b0; stub_c = '0; stub_zero = 1'b0;
    stub_ovf = 1'b0; stub_cout = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_req_ready", 64'(req_ready_a), 64'(1));
    check_eq("rst_rsp_valid", 64'(rsp_valid_a), 64'(0));
    check_eq("rst_alu_op", 64'(alu_operation_a), 64'(0));
    check_eq("rst_count", 64'(op_count_a), 64'(0));
    check_eq("rst_sticky", 64'({sts_ovf_a, sts_err_a}), 64'(0));
    step();
    rst_n = 1'b1;

    // T1: ADD, settle 1
    step();
    stub_c = 32'hDEADBEEF; stub_zero = 1'b0; stub_ovf = 1'b1; stub_cout = 1'b1;
    rsp_ready_a = 1'b1;
    send(1'b0, 3'b001, 32'd1, 32'd2, 4'd3, rsp_t'{32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3});
    @(negedge clk);
    check_eq("t1_op_drive", 64'(alu_operation_a), 64'(3'b001));
    check_eq("t1_valid_early", 64'(rsp_valid_a), 64'(0));
    @(negedge clk);
    check_eq("t1_latency", 64'(rsp_valid_a), 64'(1));
    check_eq("t1_op_one_cycle", 64'(alu_operation_a), 64'(0));
    check_eq("t1_ovf_sticky", 64'(sts_ovf_a), 64'(1));
    @(negedge clk);
    check_eq("t1_count", 64'(op_count_a), 64'(1));
    check_eq("t1_ready", 64'(req_ready_a), 64'(1));

    // T2: SUB, settle 3, response back-pressured for 5 cycles
    step();
    rsp_ready_b = 1'b0;
    stub_c = 32'd0; stub_zero = 1'b1; stub_ovf = 1'b0; stub_cout = 1'b0;
    send(1'b1, 3'b010, 32'd5, 32'd5, 4'd2, rsp_t'{32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t2_op_drive", 64'(alu_operation_b), 64'(3'b010));
      check_eq("t2_valid_early", 64'(rsp_valid_b), 64'(0));
    end
    step();
    stub_c = 32'h12345678; stub_zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t2_hold_valid", 64'(rsp_valid_b), 64'(1));
      check_eq("t2_hold_data", 64'({rsp_c_b, rsp_zero_b, rsp_tag_b}), 64'({32'd0, 1'b1, 4'd2}));
      check_eq("t2_hold_ready", 64'(req_ready_b), 64'(0));
    end
    step();
    rsp_ready_b = 1'b1;
    @(negedge clk);
    check_eq("t2_count_before", 64'(op_count_b), 64'(0));
    @(negedge clk);
    check_eq("t2_count_after", 64'(op_count_b), 64'(1));
    check_eq("t2_ready_after", 64'(req_ready_b), 64'(1));

    // T3: illegal opcode bypasses the ALU
    step();
    stub_c = 32'hFFFFFFFF; stub_zero = 1'b1; stub_ovf = 1'b1; stub_cout = 1'b1;
    send(1'b0, 3'b000, 32'd7, 32'd7, 4'd9, rsp_t'{32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9});
    @(negedge clk);
    check_eq("t3_valid", 64'(rsp_valid_a), 64'(1));
    check_eq("t3_op_idle", 64'(alu_operation_a), 64'(0));
    check_eq("t3_err_sticky", 64'(sts_err_a), 64'(1));
    @(negedge clk);
    check_eq("t3_count", 64'(op_count_a), 64'(2));

    // T4: set beats clear on the same edge, then clear alone
    step();
    stub_c = 32'd7; stub_zero = 1'b0; stub_ovf = 1'b1; stub_cout = 1'b0;
    send(1'b0, 3'b001, 32'd3, 32'd4, 4'd4, rsp_t'{32'd7, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4});
    clr_sts = 1'b1;
    step();
    clr_sts = 1'b0;
    @(negedge clk);
    check_eq("t4_ovf_set_wins", 64'(sts_ovf_a), 64'(1));
    check_eq("t4_err_cleared", 64'(sts_err_a), 64'(0));
    wait_done(1'b0);
    step();
    clr_sts = 1'b1;
    step();
    clr_sts = 1'b0;
    @(negedge clk);
    check_eq("t4_clr_alone", 64'({sts_ovf_a, sts_err_a}), 64'(0));

    // T5: reset mid-DRIVE drops the op
    step();
    stub_c = 32'h0F0F; stub_zero = 1'b0; stub_ovf = 1'b0; stub_cout = 1'b0;
    send(1'b1, 3'b011, 32'hFFFF, 32'h0F0F, 4'd5, rsp_t'{32'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5});
    step();
    check_eq("t5_op_before", 64'(alu_operation_b), 64'(3'b011));
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", 64'(rsp_valid_b), 64'(0));
    check_eq("t5_rst_op", 64'(alu_operation_b), 64'(0));
    check_eq("t5_rst_count_b", 64'(op_count_b), 64'(0));
    check_eq("t5_rst_count_a", 64'(op_count_a), 64'(0));
    exp_q_b.delete();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      send(1'b1, 3'b011, 32'hFFFF, 32'h0F0F, 4'(10 + i),
           rsp_t'{32'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 4'(10 + i)});
      wait_done(1'b1);
      if (i == 2) check_eq("t5_count_3", 64'(op_count_b), 64'(3));
    end
    check_eq("t5_count_wrap", 64'(op_count_b), 64'(0));

    // T6: reference ALU
    step();
    use_real = 1'b1;
    send(1'b0, 3'b011, 32'h0000F0F0, 32'h00000FF0, 4'd6,
         rsp_t'{32'h000000F0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6});
    wait_done(1'b0);
    step();
    send(1'b0, 3'b101, 32'hFFFFFFFF, 32'd0, 4'd7, rsp_t'{32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd7});
    wait_done(1'b0);

    check_eq("q_a_drained", 64'(exp_q_a.size()), 64'(0));
    check_eq("q_b_drained", 64'(exp_q_b.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
